// File: rtl/ms_apb_master_if.sv
// Command/response and APB completer signals of the APB master, bundled so the
// master and the bench share one declaration.
interface ms_apb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, busy
    );
endinterface

// File: rtl/ms_apb_master.sv
// Single-outstanding APB master: turns one valid/ready command into an APB
// SETUP/ACCESS transfer and returns the result on a valid/ready response port.
module ms_apb_master #(
    parameter logic [15:0] TIMEOUT  = 16'd255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input logic            PCLK,
    input logic            PRESETn,
    ms_apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_next;
    logic        accept;
    logic        done;
    logic        abort;

    logic        cmd_ready_q;
    logic        busy_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    // cmd_ready_q is the registered IDLE flag, so it also masks the reset cycle
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        done          = 1'b0;
        abort         = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    accept        = 1'b1;
                    wait_cnt_next = 16'd0;
                    next_state    = SETUP;
                end
            end
            SETUP: begin
                next_state = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    done       = 1'b1;
                    next_state = RESP;
                end else begin
                    if (wait_cnt != 16'hFFFF) begin
                        wait_cnt_next = wait_cnt + 16'd1;
                    end
                    if ((TIMEOUT != 16'd0) && (wait_cnt_next >= TIMEOUT)) begin
                        abort      = 1'b1;
                        next_state = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Every output is decoded from next_state and registered here
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= 16'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'd0;
            pwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_cnt_next;
            cmd_ready_q <= (next_state == IDLE);
            busy_q      <= (next_state != IDLE);
            psel_q      <= (next_state == SETUP) || (next_state == ACCESS);
            penable_q   <= (next_state == ACCESS);
            rsp_valid_q <= (next_state == RESP);
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
            end
            if (done) begin
                rsp_rdata_q <= pwrite_q ? 32'd0 : bus.PRDATA;
                rsp_err_q   <= bus.PSLVERR;
            end else if (abort) begin
                rsp_rdata_q <= pwrite_q ? 32'd0 : ERR_DATA;
                rsp_err_q   <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ms_apb_master.sv
// Directed bench for ms_apb_master (TIMEOUT=4): zero-wait write, wait-state read,
// timeout abort, PSLVERR with response backpressure, back-to-back issue, reset mid-transfer.
module tb_ms_apb_master;

    logic PCLK;
    logic PRESETn;
    int   checks;
    int   passes;
    int   accepts;

    ms_apb_master_if bus_if();

    ms_apb_master #(
        .TIMEOUT  (16'd4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus_if)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = write;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_wdata = wdata;
    endtask

    // Inputs are driven and outputs sampled 1 ns after each rising edge
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        checks  = 0;
        passes  = 0;
        accepts = 0;
        PRESETn = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 32'd0;
        bus_if.cmd_wdata = 32'd0;
        bus_if.rsp_ready = 1'b0;
        bus_if.PRDATA    = 32'd0;
        bus_if.PREADY    = 1'b0;
        bus_if.PSLVERR   = 1'b0;

        repeat (3) tick();
        checkOutput("rst_psel",      32'(bus_if.PSEL),      32'd0);
        checkOutput("rst_penable",   32'(bus_if.PENABLE),   32'd0);
        checkOutput("rst_paddr",     bus_if.PADDR,          32'd0);
        checkOutput("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        checkOutput("rst_busy",      32'(bus_if.busy),      32'd0);
        checkOutput("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
        PRESETn = 1'b1;
        tick();
        checkOutput("post_rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);

        // Zero-wait write
        bus_if.PREADY = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'hA5A5A5A5);
        tick();
        bus_if.cmd_valid = 1'b0;
        checkOutput("wr_setup_psel",    32'(bus_if.PSEL),      32'd1);
        checkOutput("wr_setup_penable", 32'(bus_if.PENABLE),   32'd0);
        checkOutput("wr_paddr",         bus_if.PADDR,          32'h10);
        checkOutput("wr_pwrite",        32'(bus_if.PWRITE),    32'd1);
        checkOutput("wr_pwdata",        bus_if.PWDATA,         32'hA5A5A5A5);
        checkOutput("wr_busy",          32'(bus_if.busy),      32'd1);
        checkOutput("wr_cmd_ready",     32'(bus_if.cmd_ready), 32'd0);
        tick();
        checkOutput("wr_access_penable", 32'(bus_if.PENABLE),   32'd1);
        checkOutput("wr_access_rvalid",  32'(bus_if.rsp_valid), 32'd0);
        tick();
        checkOutput("wr_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        checkOutput("wr_rsp_err",   32'(bus_if.rsp_err),   32'd0);
        checkOutput("wr_rsp_rdata", bus_if.rsp_rdata,      32'd0);
        checkOutput("wr_resp_psel", 32'(bus_if.PSEL),      32'd0);
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;
        checkOutput("wr_idle_rvalid", 32'(bus_if.rsp_valid), 32'd0);
        checkOutput("wr_idle_ready",  32'(bus_if.cmd_ready), 32'd1);
        checkOutput("wr_idle_busy",   32'(bus_if.busy),      32'd0);

        // Read with two wait states; PREADY high during SETUP must be ignored
        bus_if.PRDATA = 32'h55;
        applyStimulus(1'b0, 32'h200, 32'hFFFFFFFF);
        tick();
        bus_if.cmd_valid = 1'b0;
        tick();
        bus_if.PREADY = 1'b0;
        checkOutput("rd_acc1_penable", 32'(bus_if.PENABLE), 32'd1);
        checkOutput("rd_acc1_paddr",   bus_if.PADDR,        32'h200);
        checkOutput("rd_pwrite",       32'(bus_if.PWRITE),  32'd0);
        checkOutput("rd_pwdata",       bus_if.PWDATA,       32'd0);
        tick();
        checkOutput("rd_acc2_penable", 32'(bus_if.PENABLE), 32'd1);
        checkOutput("rd_acc2_paddr",   bus_if.PADDR,        32'h200);
        tick();
        bus_if.PREADY = 1'b1;
        bus_if.PRDATA = 32'h7;
        checkOutput("rd_acc3_penable", 32'(bus_if.PENABLE),   32'd1);
        checkOutput("rd_acc3_paddr",   bus_if.PADDR,          32'h200);
        checkOutput("rd_acc3_rvalid",  32'(bus_if.rsp_valid), 32'd0);
        tick();
        bus_if.PREADY = 1'b0;
        checkOutput("rd_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
        checkOutput("rd_rsp_rdata", bus_if.rsp_rdata,      32'h7);
        checkOutput("rd_rsp_err",   32'(bus_if.rsp_err),   32'd0);
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;

        // Read timing out after four ACCESS cycles
        applyStimulus(1'b0, 32'h300, 32'd0);
        tick();
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("to_access_penable", 32'(bus_if.PENABLE),   32'd1);
            checkOutput("to_access_rvalid",  32'(bus_if.rsp_valid), 32'd0);
        end
        tick();
        checkOutput("to_rsp_valid",   32'(bus_if.rsp_valid), 32'd1);
        checkOutput("to_rsp_rdata",   bus_if.rsp_rdata,      32'hDEADBEEF);
        checkOutput("to_rsp_err",     32'(bus_if.rsp_err),   32'd1);
        checkOutput("to_resp_psel",   32'(bus_if.PSEL),      32'd0);
        checkOutput("to_resp_penable", 32'(bus_if.PENABLE),  32'd0);
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;
        checkOutput("to_idle_ready", 32'(bus_if.cmd_ready), 32'd1);

        // Write with PSLVERR and a stalled response consumer
        bus_if.PREADY  = 1'b1;
        bus_if.PSLVERR = 1'b1;
        applyStimulus(1'b1, 32'h44, 32'h12345678);
        tick();
        bus_if.cmd_valid = 1'b0;
        tick();
        tick();
        bus_if.PSLVERR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("err_hold_rvalid", 32'(bus_if.rsp_valid), 32'd1);
            checkOutput("err_hold_err",    32'(bus_if.rsp_err),   32'd1);
            checkOutput("err_hold_rdata",  bus_if.rsp_rdata,      32'd0);
            checkOutput("err_hold_ready",  32'(bus_if.cmd_ready), 32'd0);
            tick();
        end
        checkOutput("err_still_rvalid", 32'(bus_if.rsp_valid), 32'd1);
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;
        checkOutput("err_idle_rvalid", 32'(bus_if.rsp_valid), 32'd0);
        checkOutput("err_idle_ready",  32'(bus_if.cmd_ready), 32'd1);

        // Back-to-back commands: one accept every four cycles
        bus_if.rsp_ready = 1'b1;
        applyStimulus(1'b0, 32'h80, 32'd0);
        for (int k = 0; k < 12; k++) begin
            checkOutput("b2b_cmd_ready", 32'(bus_if.cmd_ready), (k % 4 == 0) ? 32'd1 : 32'd0);
            checkOutput("b2b_busy",      32'(bus_if.busy),      (k % 4 != 0) ? 32'd1 : 32'd0);
            checkOutput("b2b_rsp_valid", 32'(bus_if.rsp_valid), (k % 4 == 3) ? 32'd1 : 32'd0);
            if (bus_if.cmd_valid && bus_if.cmd_ready) accepts++;
            tick();
        end
        bus_if.cmd_valid = 1'b0;
        bus_if.rsp_ready = 1'b0;
        checkOutput("b2b_accepts", 32'(accepts), 32'd3);

        // Reset asserted in the middle of an ACCESS phase
        bus_if.PREADY = 1'b0;
        applyStimulus(1'b0, 32'h400, 32'd0);
        tick();
        bus_if.cmd_valid = 1'b0;
        tick();
        checkOutput("rst_acc_penable", 32'(bus_if.PENABLE), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        checkOutput("rst_mid_psel",    32'(bus_if.PSEL),      32'd0);
        checkOutput("rst_mid_penable", 32'(bus_if.PENABLE),   32'd0);
        checkOutput("rst_mid_busy",    32'(bus_if.busy),      32'd0);
        checkOutput("rst_mid_ready",   32'(bus_if.cmd_ready), 32'd0);
        tick();
        PRESETn = 1'b1;
        checkOutput("rst_rel_rvalid", 32'(bus_if.rsp_valid), 32'd0);
        checkOutput("rst_rel_paddr",  bus_if.PADDR,          32'd0);
        tick();
        checkOutput("rst_after_ready",  32'(bus_if.cmd_ready), 32'd1);
        checkOutput("rst_after_rvalid", 32'(bus_if.rsp_valid), 32'd0);
        checkOutput("rst_after_psel",   32'(bus_if.PSEL),      32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
